systolic_drain: RTL and testbench
=================================

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter ACC_W, default 32: accumulator/result width.
REQ-002 SHALL have parameter M, default 4: PE rows.
REQ-003 SHALL have parameter N, default 4: PE columns.
REQ-004 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles (used only with SYSTOLIC_DRAIN_TIMEOUT_EN).
REQ-005 SHALL derive localparam IDX_W = clog2(M*N), minimum 1.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port pe_out  input  M*N*ACC_W  flattened PE accumulators; PE k = row*N+col occupies bits [k*ACC_W +: ACC_W].
REQ-009 SHALL have port pe_out_valid  input  M*N  per-PE result valid.
REQ-010 SHALL have port pe_out_ready  output  M*N  per-PE result accept.
REQ-011 SHALL have port res_data  output  ACC_W  serialized result.
REQ-012 SHALL have port res_idx  output  IDX_W  PE index of res_data.
REQ-013 SHALL have port res_last  output  1  high with index M*N-1.
REQ-014 SHALL have port res_valid  output  1  output stream valid.
REQ-015 SHALL have port res_ready  input  1  downstream accept.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse on acceptance of the last word.
REQ-017 SHALL have port timeout_err  output  1  current word was substituted by the watchdog.

Function
REQ-018 SHALL drain PEs strictly in row-major order 0..M*N-1, then wrap to 0 and start the next frame.
REQ-019 SHALL hold scan pointer idx; pe_out_ready SHALL be one-hot at bit idx when the output register is empty or (res_valid & res_ready), else all-zero.
REQ-020 SHALL capture on pe_out_valid[idx] & pe_out_ready[idx]: res_data<=PE word, res_idx<=idx, res_last<=(idx==M*N-1), res_valid<=1, idx<=idx+1 (wrap to 0 after M*N-1).
REQ-021 SHALL keep res_data/res_idx/res_last stable while res_valid & !res_ready.
REQ-022 SHALL clear res_valid on res_valid & res_ready when no capture occurs in that cycle.
REQ-023 SHALL sustain 1 word/cycle when consume and capture coincide; latency pe_out_valid -> res_valid = 1 cycle.
REQ-024 SHALL ignore pe_out_valid on bits other than idx.
REQ-025 SHALL pulse frame_done one cycle after the cycle in which res_last & res_valid & res_ready.
REQ-026 SHALL implement FSM: WAIT (pointer waiting for PE), HOLD (register full, downstream stalled, no capture); WAIT->HOLD on capture with !res_ready next; HOLD->WAIT on res_ready.

Reset
REQ-027 SHALL, on rst, set idx=0, res_valid=0, res_data=0, res_idx=0, res_last=0, frame_done=0, timeout_err=0, watchdog=0, state=WAIT.
REQ-028 SHALL let rst mid-frame discard any held word and restart at PE 0 on the next cycle; pe_out_ready SHALL be 0 during rst.

Configuration
REQ-029 SHALL use macro SYSTOLIC_DRAIN_TIMEOUT_EN for the watchdog.
REQ-030 With macro: SHALL count cycles in WAIT with pe_out_valid[idx]=0 and the output register free; at TIMEOUT it SHALL emit res_data=0, timeout_err=1 (travels with word), advance idx, clear count; count clears on every capture.
REQ-031 Without macro: no counter, timeout_err tied 0, drain waits indefinitely.

Verification
REQ-032 All 16 PEs valid with values k*3, res_ready=1 -> 16 words, one per cycle, res_idx 0..15, data 0,3,...,45, res_last only on 15, frame_done once.
REQ-033 Only PE 5 valid first -> pe_out_ready stays 0x0001, nothing emitted until PE 0 valid; order preserved.
REQ-034 res_ready low for 4 cycles with word 2 held -> res_data/res_idx unchanged, pe_out_ready=0, resume emits idx 3 next.
REQ-035 rst asserted after word 7 accepted -> res_valid=0 next cycle, next emitted res_idx=0.
REQ-036 Two back-to-back frames -> idx wraps 15->0 with no bubble, frame_done pulses twice.
REQ-037 With SYSTOLIC_DRAIN_TIMEOUT_EN, TIMEOUT=8, PE 4 never valid -> after 8 idle cycles word idx 4 = 0 with timeout_err=1, then idx 5 normal.

Source files
------------

// File: rtl/systolic_drain_if.sv
// Handshake bundle between the PE array, the result drain and the downstream consumer.
// Slave modport is the drain's view; master modport is the environment's view.
interface systolic_drain_if #(
    parameter int ACC_W = 32,
    parameter int M     = 4,
    parameter int N     = 4
);
    localparam int IDX_W = (M * N > 1) ? $clog2(M * N) : 1;

    logic [M*N*ACC_W-1:0] pe_out;
    logic [M*N-1:0]       pe_out_valid;
    logic [M*N-1:0]       pe_out_ready;
    logic [ACC_W-1:0]     res_data;
    logic [IDX_W-1:0]     res_idx;
    logic                 res_last;
    logic                 res_valid;
    logic                 res_ready;
    logic                 frame_done;
    logic                 timeout_err;

    modport slave (
        input  pe_out, pe_out_valid, res_ready,
        output pe_out_ready, res_data, res_idx, res_last, res_valid, frame_done, timeout_err
    );

    modport master (
        output pe_out, pe_out_valid, res_ready,
        input  pe_out_ready, res_data, res_idx, res_last, res_valid, frame_done, timeout_err
    );
endinterface

// File: rtl/systolic_drain.sv
// Serializes an M x N PE accumulator array into one result stream in row-major order.
// Optional stall watchdog enabled by SYSTOLIC_DRAIN_TIMEOUT_EN (substitutes a zero word).
module systolic_drain #(
    parameter int ACC_W   = 32,
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    systolic_drain_if.slave bus
);
    localparam int NPE   = M * N;
    localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPE - 1);

    typedef enum logic {S_WAIT, S_HOLD} state_t;

    state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [ACC_W-1:0]          r_res_data;
    logic [IDX_W-1:0]          r_res_idx;
    logic                      r_res_last;
    logic                      r_res_valid;
    logic                      r_frame_done;

    logic [NPE-1:0][ACC_W-1:0] w_pe;
    logic [ACC_W-1:0]          w_word;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [NPE-1:0]            w_rdy;
    logic                      w_consume;
    logic                      w_slot_free;
    logic                      w_cap;
    logic                      w_tmo;
    logic                      w_load;

    // Packed view of the flattened bus: element k is PE k.
    assign w_pe        = bus.pe_out;
    assign w_word      = w_pe[r_idx];
    assign w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

    assign w_consume   = r_res_valid & bus.res_ready;
    assign w_slot_free = ~r_res_valid | w_consume;
    assign w_cap       = ~rst & w_slot_free & bus.pe_out_valid[r_idx];
    assign w_load      = w_cap | w_tmo;

    always_comb begin
        w_rdy = '0;
        if (!rst && w_slot_free)
            w_rdy[r_idx] = 1'b1;
    end

    assign bus.pe_out_ready = w_rdy;
    assign bus.res_data     = r_res_data;
    assign bus.res_idx      = r_res_idx;
    assign bus.res_last     = r_res_last;
    assign bus.res_valid    = r_res_valid;
    assign bus.frame_done   = r_frame_done;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_WAIT;
        else
            r_state <= w_state_nxt;
    end

    // HOLD marks a full output register facing a stalled consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT:  if (r_res_valid && !bus.res_ready) w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.res_ready)                 w_state_nxt = S_WAIT;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_res_data   <= '0;
            r_res_idx    <= '0;
            r_res_last   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_consume & r_res_last;
            if (w_load) begin
                r_res_data  <= w_cap ? w_word : '0;
                r_res_idx   <= r_idx;
                r_res_last  <= (r_idx == LAST_IDX);
                r_res_valid <= 1'b1;
                r_idx       <= w_idx_nxt;
            end else if (w_consume) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_tmo;
    logic            w_idle;

    // Idle = pointer starved while the output register could accept a word.
    assign w_idle = ~rst & (r_state == S_WAIT) & w_slot_free & ~bus.pe_out_valid[r_idx];
    assign w_tmo  = w_idle & (r_wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || w_cap || w_tmo)
            r_wdog <= '0;
        else if (w_idle)
            r_wdog <= r_wdog + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_tmo <= 1'b0;
        else if (w_load)
            r_tmo <= w_tmo;
        else if (w_consume)
            r_tmo <= 1'b0;
    end

    assign bus.timeout_err = r_tmo;
`else
    assign w_tmo           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_drain.sv
// Randomized bench for systolic_drain: PEs present per-frame values from a random table,
// and the output stream is compared with the word order those values imply.
module tb_systolic_drain;
    localparam int ACC_W = 32;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int NPE   = M * N;
    localparam int IDX_W = 4;
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [ACC_W-1:0] vals [32][NPE];
    int               fcnt [NPE];
    int               rbase = 0;
    int               ocnt  = 0;
    int               cap   = 0;

    systolic_drain_if #(.ACC_W(ACC_W), .M(M), .N(N)) bus ();

    systolic_drain #(.ACC_W(ACC_W), .M(M), .N(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each PE walks through frames of the value table as its results are taken.
    always @(posedge clk) begin
        for (int k = 0; k < NPE; k++) begin
            if (rst)
                fcnt[k] <= rbase;
            else if (bus.pe_out_valid[k] && bus.pe_out_ready[k])
                fcnt[k] <= fcnt[k] + 1;
        end
    end

    always_comb begin
        bus.pe_out = '0;
        for (int k = 0; k < NPE; k++)
            bus.pe_out[k*ACC_W +: ACC_W] = vals[fcnt[k] % 32][k];
    end

    function automatic logic [NPE-1:0] vmask(input int limit);
        logic [NPE-1:0] m;
        m = '0;
        for (int k = 0; k < NPE; k++)
            m[k] = (fcnt[k] < limit);
        return m;
    endfunction

    function automatic logic [ACC_W-1:0] exp_data(input int o);
        return vals[(o / NPE) % 32][o % NPE];
    endfunction

    task automatic tick(input logic [NPE-1:0] v, input logic rr, input logic r);
        @(negedge clk);
        bus.pe_out_valid = v;
        bus.res_ready    = rr;
        rst              = r;
        #1;
    endtask

    task automatic do_reset(input int base);
        rbase = base;
        tick('0, 1'b1, 1'b1);
        tick('0, 1'b1, 1'b0);
        ocnt = base * NPE;
        cap  = 0;
    endtask

    task automatic test_reset();
        rbase = 0;
        tick('1, 1'b1, 1'b1);
        tick('1, 1'b1, 1'b1);
        total++;
        if (bus.pe_out_ready !== '0) begin
            bad++; $display("FAIL reset_ready got=%h exp=0", bus.pe_out_ready);
        end
        total++;
        if ({bus.res_valid, bus.res_last, bus.frame_done, bus.timeout_err} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000",
                            {bus.res_valid, bus.res_last, bus.frame_done, bus.timeout_err});
        end
        total++;
        if (bus.res_data !== '0 || bus.res_idx !== '0) begin
            bad++; $display("FAIL reset_regs data=%h idx=%0d exp=0/0", bus.res_data, bus.res_idx);
        end
        tick('0, 1'b1, 1'b0);
        total++;
        if (bus.pe_out_ready !== 16'h0001) begin
            bad++; $display("FAIL reset_ptr got=%h exp=0001", bus.pe_out_ready);
        end
        ocnt = 0;
        cap  = 0;
    endtask

    task automatic test_full_frame();
        int words = 0, fd = 0, first = -1, lastc = -1;
        for (int c = 0; c < 40; c++) begin
            tick(vmask(1), 1'b1, 1'b0);
            if (bus.frame_done) fd++;
            if (bus.res_valid) begin
                total++;
                if (bus.res_idx !== IDX_W'(words) || bus.res_data !== ACC_W'(words * 3) ||
                    bus.res_last !== (words == NPE - 1) || bus.timeout_err !== 1'b0) begin
                    bad++; $display("FAIL full_word got idx=%0d data=%0d last=%b exp idx=%0d data=%0d",
                                    bus.res_idx, bus.res_data, bus.res_last, words, words * 3);
                end
                if (first < 0) first = c;
                lastc = c;
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != NPE || fd != 1 || lastc - first != NPE - 1) begin
            bad++; $display("FAIL full_frame words=%0d fd=%0d span=%0d exp 16/1/15", words, fd, lastc - first);
        end
    endtask

    task automatic test_order();
        int words = 0;
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            tick(16'h0020, 1'b1, 1'b0);
            total++;
            if (bus.pe_out_ready !== 16'h0001 || bus.res_valid !== 1'b0) begin
                bad++; $display("FAIL order_wait ready=%h valid=%b exp 0001/0", bus.pe_out_ready, bus.res_valid);
            end
        end
        for (int c = 0; c < 40 && words < NPE; c++) begin
            tick(vmask(2), 1'b1, 1'b0);
            if (bus.res_valid && bus.res_ready) begin
                total++;
                if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt)) begin
                    bad++; $display("FAIL order_word got idx=%0d data=%h exp idx=%0d data=%h",
                                    bus.res_idx, bus.res_data, ocnt % NPE, exp_data(ocnt));
                end
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != NPE) begin
            bad++; $display("FAIL order_count got=%0d exp=16", words);
        end
    endtask

    task automatic test_stall();
        int   words = 0, stall = 0, held = 0;
        logic armed = 1'b1, chk_next = 1'b0;
        do_reset(2);
        for (int c = 0; c < 60 && words < NPE; c++) begin
            tick(vmask(3), (stall == 0), 1'b0);
            if (chk_next) begin
                chk_next = 1'b0;
                total++;
                if (bus.res_valid !== 1'b1 || bus.res_idx !== IDX_W'(3)) begin
                    bad++; $display("FAIL stall_resume valid=%b idx=%0d exp 1/3", bus.res_valid, bus.res_idx);
                end
            end
            if (stall > 0) begin
                total++;
                if (bus.res_valid !== 1'b1 || bus.res_idx !== IDX_W'(2) ||
                    bus.res_data !== exp_data(ocnt) || bus.pe_out_ready !== '0) begin
                    bad++; $display("FAIL stall_hold idx=%0d data=%h ready=%h exp 2/%h/0",
                                    bus.res_idx, bus.res_data, bus.pe_out_ready, exp_data(ocnt));
                end
                stall--;
                held++;
            end else if (bus.res_valid && bus.res_ready) begin
                total++;
                if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt)) begin
                    bad++; $display("FAIL stall_word got idx=%0d data=%h exp idx=%0d data=%h",
                                    bus.res_idx, bus.res_data, ocnt % NPE, exp_data(ocnt));
                end
                if (ocnt % NPE == 1 && armed) begin
                    stall = 4;
                    armed = 1'b0;
                end
                if (ocnt % NPE == 2) chk_next = 1'b1;
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != NPE || held != 4) begin
            bad++; $display("FAIL stall_count words=%0d held=%0d exp 16/4", words, held);
        end
    endtask

    task automatic test_reset_mid();
        int words = 0;
        logic done7 = 1'b0;
        do_reset(3);
        for (int c = 0; c < 40 && !done7; c++) begin
            tick(vmask(4), 1'b1, 1'b0);
            if (bus.res_valid && bus.res_ready) begin
                if (ocnt % NPE == 7) done7 = 1'b1;
                ocnt++;
            end
        end
        rbase = 4;
        tick(vmask(4), 1'b1, 1'b1);
        total++;
        if (bus.pe_out_ready !== '0) begin
            bad++; $display("FAIL rstmid_ready got=%h exp=0", bus.pe_out_ready);
        end
        tick(vmask(5), 1'b1, 1'b0);
        total++;
        if (bus.res_valid !== 1'b0 || !done7) begin
            bad++; $display("FAIL rstmid_valid got=%b reached7=%b exp 0/1", bus.res_valid, done7);
        end
        ocnt = 4 * NPE;
        for (int c = 0; c < 40 && words < NPE; c++) begin
            tick(vmask(5), 1'b1, 1'b0);
            if (bus.res_valid && bus.res_ready) begin
                total++;
                if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt)) begin
                    bad++; $display("FAIL rstmid_word got idx=%0d data=%h exp idx=%0d data=%h",
                                    bus.res_idx, bus.res_data, ocnt % NPE, exp_data(ocnt));
                end
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != NPE) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=16", words);
        end
    endtask

    task automatic test_back_to_back();
        int words = 0, fd = 0, first = -1, lastc = -1;
        do_reset(5);
        for (int c = 0; c < 50; c++) begin
            tick(vmask(7), 1'b1, 1'b0);
            if (bus.frame_done) fd++;
            if (bus.res_valid && bus.res_ready) begin
                total++;
                if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt) ||
                    bus.res_last !== (ocnt % NPE == NPE - 1)) begin
                    bad++; $display("FAIL b2b_word got idx=%0d data=%h last=%b exp idx=%0d data=%h",
                                    bus.res_idx, bus.res_data, bus.res_last, ocnt % NPE, exp_data(ocnt));
                end
                if (first < 0) first = c;
                lastc = c;
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != 2 * NPE || fd != 2 || lastc - first != 2 * NPE - 1) begin
            bad++; $display("FAIL b2b_summary words=%0d fd=%0d span=%0d exp 32/2/31", words, fd, lastc - first);
        end
    endtask

    task automatic test_random();
        int             words = 0;
        logic           prev_last = 1'b0;
        logic           acc;
        logic [NPE-1:0] v;
        do_reset(7);
        for (int c = 0; c < 1000 && words < 6 * NPE; c++) begin
            v = vmask(13) & NPE'($urandom | $urandom);
            tick(v, ($urandom_range(0, 3) != 0), 1'b0);
            acc = bus.res_valid && bus.res_ready;
            total++;
            if (bus.pe_out_ready !== '0 && bus.pe_out_ready !== (16'h0001 << (cap % NPE))) begin
                bad++; $display("FAIL rand_ready got=%h exp=0 or %h", bus.pe_out_ready, 16'h0001 << (cap % NPE));
            end
            total++;
            if (bus.frame_done !== prev_last) begin
                bad++; $display("FAIL rand_fdone got=%b exp=%b", bus.frame_done, prev_last);
            end
            if ((bus.pe_out_valid & bus.pe_out_ready) != '0) cap++;
            prev_last = acc && bus.res_last;
            if (acc) begin
                total++;
                if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt) ||
                    bus.res_last !== (ocnt % NPE == NPE - 1) || bus.timeout_err !== 1'b0) begin
                    bad++; $display("FAIL rand_word got idx=%0d data=%h last=%b exp idx=%0d data=%h",
                                    bus.res_idx, bus.res_data, bus.res_last, ocnt % NPE, exp_data(ocnt));
                end
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != 6 * NPE) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", words, 6 * NPE);
        end
    endtask

`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        int words = 0, c3 = -1, c4 = -1;
        do_reset(13);
        for (int c = 0; c < 80 && words < NPE; c++) begin
            tick(vmask(14) & ~16'h0010, 1'b1, 1'b0);
            if (bus.res_valid && bus.res_ready) begin
                total++;
                if (bus.res_idx == IDX_W'(4)) begin
                    c4 = c;
                    if (bus.res_data !== '0 || bus.timeout_err !== 1'b1) begin
                        bad++; $display("FAIL tmo_word data=%h err=%b exp 0/1", bus.res_data, bus.timeout_err);
                    end
                end else begin
                    if (bus.res_idx == IDX_W'(3)) c3 = c;
                    if (bus.res_idx !== IDX_W'(ocnt % NPE) || bus.res_data !== exp_data(ocnt) ||
                        bus.timeout_err !== 1'b0) begin
                        bad++; $display("FAIL tmo_normal got idx=%0d data=%h err=%b exp idx=%0d data=%h",
                                        bus.res_idx, bus.res_data, bus.timeout_err, ocnt % NPE, exp_data(ocnt));
                    end
                end
                words++;
                ocnt++;
            end
        end
        total++;
        if (words != NPE || c4 - c3 != TMO) begin
            bad++; $display("FAIL tmo_gap words=%0d gap=%0d exp 16/%0d", words, c4 - c3, TMO);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst              = 1'b1;
        bus.pe_out_valid = '0;
        bus.res_ready    = 1'b0;
        for (int f = 0; f < 32; f++)
            for (int k = 0; k < NPE; k++)
                vals[f][k] = (f == 0) ? ACC_W'(k * 3) : ACC_W'($urandom);
        test_reset();
        test_full_frame();
        test_order();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SYSTOLIC_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
